instr_fetch_unit: RTL and testbench

- Parametrised, decoupled instruction-fetch front end for the next-generation SimpleCPU core.
- Replaces the direct PC register to ROM to decode path with a pipelined request/grant instruction-memory interface and a prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Computes branch, jump and register redirect targets internally, and discards stale in-flight fetches after a redirect.

---
 rtl/instr_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Decoupled instruction-fetch front end. A fetch PC drives a pipelined
// request/grant instruction-memory port; in-order responses land in a small
// prefetch FIFO whose head is offered to decode over a valid/ready handshake.
// Redirects (resync, relative branch, jump, register) compute their target
// here, flush the FIFO and drop every response still in flight.
//
// Issue is credit based: FIFO occupancy plus granted-but-unreturned requests
// never exceeds FIFO_DEPTH, so a response always has a free slot.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address
//   imem_gnt          request accepted this cycle
//   imem_rvalid/rdata in-order response
//   instr_valid/ready decode handshake on the FIFO head
//   instr_data/pc     head instruction and its PC
//   instr_pc_plus4    head PC + 4
//   redir_valid       single-cycle redirect strobe
//   redir_mode        00 resync, 01 branch, 10 jump, 11 register
//   redir_pc/imm/index/reg  redirect operands
//   fetch_misalign    (FETCH_MISALIGN_CHK_EN only) misaligned-target stall
//
// Build option:
//   FETCH_MISALIGN_CHK_EN  when defined, a redirect to a target with nonzero
//                          low bits raises fetch_misalign and stalls fetch
//                          until an aligned redirect. Otherwise the low two
//                          target bits are simply forced to zero.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus4,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic              fetch_misalign,
`endif
    input  logic              redir_valid,
    input  logic [1:0]        redir_mode,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_index,
    input  logic [ADDR_W-1:0] redir_reg
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        REDIR_RESYNC = 2'b00,
        REDIR_BRANCH = 2'b01,
        REDIR_JUMP   = 2'b10,
        REDIR_REG    = 2'b11
    } redir_mode_e;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];

    logic [ADDR_W-1:0] p4;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target;
    logic [CW:0]       credit_used;
    logic              stall;
    logic              xfer;
    logic              rsp;
    logic              push;
    logic              pop;

    // Redirect target.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        p4         = redir_pc + ADDR_W'(4);
        target_raw = p4;
        unique case (redir_mode_e'(redir_mode))
            REDIR_RESYNC: target_raw = p4;
            REDIR_BRANCH: target_raw = p4 + {{(ADDR_W-18){redir_imm[15]}}, redir_imm, 2'b00};
            REDIR_JUMP:   target_raw[27:0] = {redir_index, 2'b00};
            REDIR_REG:    target_raw = redir_reg;
        endcase
        target = target_raw & ~ADDR_W'(3);
    end

    // Handshakes. imem_req is also gated by rst_n so nothing is offered
    // to memory while reset is held.
    always_comb begin
        credit_used = (CW+1)'(count) + (CW+1)'(outstanding);
        imem_req    = rst_n && !redir_valid && !stall && (credit_used < (CW+1)'(FIFO_DEPTH));
        xfer        = imem_req && imem_gnt;
        // A response with nothing outstanding is unexpected and ignored.
        rsp         = imem_rvalid && (outstanding != '0);
        push        = rsp && (discard == '0) && !redir_valid;
        pop         = instr_valid && instr_ready && !redir_valid;
    end

    assign imem_addr      = fetch_pc;
    assign instr_valid    = (count != '0);
    assign instr_data     = fifo_data[rd_ptr];
    assign instr_pc       = fifo_pc[rd_ptr];
    assign instr_pc_plus4 = instr_pc + ADDR_W'(4);

    // Control state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            // No transfer can happen in a redirect cycle (imem_req is low).
            outstanding <= outstanding + CW'(xfer) - CW'(rsp);
            if (redir_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                // Everything still in flight after this edge is stale.
                discard  <= outstanding - CW'(rsp);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (xfer)
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                if (rsp && (discard != '0))
                    discard <= discard - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(4);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Prefetch storage.
    // NOTE: storage is reset so the head outputs read 0 / RESET_PC before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= RESET_PC;
            end
        end else if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Set by a misaligned redirect, cleared by the next aligned one. The
    // redirect already flushed the FIFO and discards all in-flight data, so
    // blocking new requests is enough to keep instr_valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_misalign <= 1'b0;
        else if (redir_valid)
            fetch_misalign <= (target_raw[1:0] != 2'b00);
    end
    assign stall = fetch_misalign;
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] instr_pc_plus4;
    logic          redir_valid = 1'b0;
    logic [1:0]    redir_mode = '0;
    logic [AW-1:0] redir_pc = '0;
    logic [15:0]   redir_imm = '0;
    logic [25:0]   redir_index = '0;
    logic [AW-1:0] redir_reg = '0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          fetch_misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .redir_valid(redir_valid), .redir_mode(redir_mode), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_index(redir_index), .redir_reg(redir_reg)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Memory model: granted addresses with the cycle their response is due.
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc;
    int          grants;
    int          pops;
    logic [31:0] exp_pc;        // PC the next accepted instruction must carry
    logic [31:0] first_pop_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] mode, input logic [31:0] pc,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] rs);
        logic [31:0] p4;
        logic [31:0] t;
        int          off;
        p4  = pc + 32'd4;
        off = int'($signed(imm)) * 4;
        case (mode)
            2'd0:    t = p4;
            2'd1:    t = p4 + 32'(off);
            2'd2:    t = (p4 & 32'hF000_0000) + 32'(idx) * 32'd4;
            default: t = rs;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    // Called just after a falling edge: drive this cycle's inputs, then
    // sample outputs and account for what the coming rising edge commits.
    task automatic drive(input logic gnt, input logic rdy, input int lat);
        imem_gnt    = gnt;
        instr_ready = rdy;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (imem_req && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
            grants++;
        end
        if (instr_valid && instr_ready && !redir_valid) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_data", instr_data, memf(exp_pc));
            check("pop_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
            if (pops == 0) first_pop_pc = instr_pc;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redir_valid)
            exp_pc = ref_target(redir_mode, redir_pc, redir_imm, redir_index, redir_reg);
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        redir_valid = 1'b0;
        q_addr.delete();
        q_due.delete();
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_data", instr_data, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
        rst_n        = 1'b1;
        cyc          = 0;
        grants       = 0;
        pops         = 0;
        exp_pc       = 32'h0;
        first_pop_pc = 32'hDEAD_BEEF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming: full grant, 1-cycle latency, decode always ready.
        do_reset();
        drive(1'b1, 1'b1, 1);
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        adv();
        drive(1'b1, 1'b1, 1);
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", 32'(instr_valid), 32'd0);
        adv();
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 1'b1, 1);
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_addr", imem_addr, 32'(4 * i));
            adv();
        end

        // Decode stalled: exactly DEPTH requests, head held.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1);
            if (i >= 2) begin
                check("stall_head_pc", instr_pc, 32'h0);
                check("stall_head_data", instr_data, memf(32'h0));
            end
            adv();
        end
        check("stall_grants", 32'(grants), 32'(DEPTH));
        drive(1'b1, 1'b1, 1);
        check("stall_req_low", 32'(imem_req), 32'd0);
        adv();
        drive(1'b1, 1'b1, 1);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h10);
        adv();

        // Branch with three requests outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5);
            adv();
        end
        redir_valid = 1'b1; redir_mode = 2'd1; redir_pc = 32'h100; redir_imm = 16'hFFFE;
        drive(1'b1, 1'b1, 5);
        check("br_req_low", 32'(imem_req), 32'd0);
        adv();
        drive(1'b1, 1'b1, 1);
        check("br_addr", imem_addr, 32'hFC);
        adv();
        for (int g = 0; g < 30 && pops == 0; g++) begin
            drive(1'b1, 1'b1, 1);
            adv();
        end
        check("br_pop_seen", 32'(pops > 0), 32'd1);
        check("br_first_pc", first_pop_pc, 32'hFC);

        // Jump and register redirects.
        redir_valid = 1'b1; redir_mode = 2'd2; redir_pc = 32'hF000_0010; redir_index = 26'h40;
        drive(1'b1, 1'b1, 1);
        adv();
        drive(1'b1, 1'b1, 1);
        check("jmp_addr", imem_addr, 32'hF000_0100);
        adv();
        redir_valid = 1'b1; redir_mode = 2'd3; redir_reg = 32'h2000;
        drive(1'b1, 1'b1, 1);
        adv();
        drive(1'b1, 1'b1, 1);
        check("reg_addr", imem_addr, 32'h2000);
        adv();
`ifndef FETCH_MISALIGN_CHK_EN
        redir_valid = 1'b1; redir_mode = 2'd3; redir_reg = 32'h2003;
        drive(1'b1, 1'b1, 1);
        adv();
        drive(1'b1, 1'b1, 1);
        check("reg_align_addr", imem_addr, 32'h2000);
        adv();
`endif
        repeat (8) begin
            drive(1'b1, 1'b1, 1);
            adv();
        end

        // Redirect coinciding with a response and a pop, one outstanding.
        do_reset();
        drive(1'b1, 1'b1, 1);
        adv();
        drive(1'b1, 1'b1, 1);
        adv();
        redir_valid = 1'b1; redir_mode = 2'd0; redir_pc = 32'h40;
        drive(1'b0, 1'b1, 1);
        check("same_valid_before", 32'(instr_valid), 32'd1);
        check("same_req_low", 32'(imem_req), 32'd0);
        adv();
        pops = 0;
        drive(1'b0, 1'b1, 1);
        check("same_empty", 32'(instr_valid), 32'd0);
        check("same_addr", imem_addr, 32'h44);
        adv();
        for (int g = 0; g < 20 && pops == 0; g++) begin
            drive(1'b1, 1'b1, 1);
            adv();
        end
        check("same_first_pc", first_pop_pc, 32'h44);

        // Randomized traffic checked against the stream model.
        pops = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                redir_valid = 1'b1;
                redir_mode  = 2'($urandom);
                redir_pc    = $urandom & 32'hFFFF_FFFC;
                redir_imm   = 16'($urandom);
                redir_index = 26'($urandom);
                redir_reg   = $urandom & 32'hFFFF_FFFC;
            end
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(1, 3));
            adv();
        end
        check("rand_progress", 32'(pops > 100), 32'd1);

`ifdef FETCH_MISALIGN_CHK_EN
        redir_valid = 1'b1; redir_mode = 2'd3; redir_reg = 32'h2002;
        drive(1'b1, 1'b1, 1);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1);
            check("mis_flag", 32'(fetch_misalign), 32'd1);
            check("mis_req", 32'(imem_req), 32'd0);
            check("mis_valid", 32'(instr_valid), 32'd0);
            adv();
        end
        redir_valid = 1'b1; redir_mode = 2'd3; redir_reg = 32'h3000;
        drive(1'b1, 1'b1, 1);
        adv();
        drive(1'b1, 1'b1, 1);
        check("mis_clear", 32'(fetch_misalign), 32'd0);
        check("mis_resume_req", 32'(imem_req), 32'd1);
        check("mis_resume_addr", imem_addr, 32'h3000);
        adv();
        repeat (6) begin
            drive(1'b1, 1'b1, 1);
            adv();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
